dma_peripheral_port: RTL and testbench

DMA_PERIPHERAL_PORT -- requirements
Module: dma_peripheral_port

---
 rtl/dma_peripheral_port.sv | 139 +++++++++++++
 tb/tb_dma_peripheral_port.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dma_peripheral_port.sv
// Peripheral side of a demand-mode DMA channel: 8-deep byte FIFO between a
// device and a DMA controller. Transfers are paced by DREQ/DACK and the IOR/IOW strobes.
module dma_peripheral_port (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       dir,
    output logic       DREQ,
    input  logic       DACK,
    input  logic       IOR,
    input  logic       IOW,
    input  logic       EOP,
    input  logic [7:0] DMA_data_bus_in,
    output logic [7:0] DMA_data_bus_out,
    input  logic       dev_wr_en,
    input  logic [7:0] dev_wr_data,
    input  logic       dev_rd_en,
    output logic [7:0] dev_rd_data,
    output logic [3:0] fifo_count,
    output logic       dev_full,
    output logic       dev_empty,
    output logic       done,
    output logic       overflow,
    output logic       underrun
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] XFER  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0] state_q, state_d;
    logic       dir_q, dir_d;
    logic [7:0] mem_q [8];
    logic [2:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [3:0] count_q, count_d;
    logic [7:0] head_q, head_d;
    logic       dreq_q, dreq_d;
    logic       ior_q, iow_q;
    logic       done_q, ovf_q, unr_q;

    logic       empty, full, xfer_act, ior_edge, iow_edge;
    logic       dma_pop_req, dma_push_req, pop_req, push_req, do_pop, do_push;
    logic [7:0] wdata;

    assign empty    = (count_q == 4'd0);
    assign full     = (count_q == 4'd8);
    assign ior_edge = IOR & ~ior_q;
    assign iow_edge = IOW & ~iow_q;
    assign xfer_act = (state_q == XFER) && DACK;

    // DMA side only moves data on a strobe edge while acknowledged in XFER
    assign dma_pop_req  = xfer_act && !dir_q && ior_edge;
    assign dma_push_req = xfer_act &&  dir_q && iow_edge;
    assign pop_req      = dma_pop_req  | dev_rd_en;
    assign push_req     = dma_push_req | dev_wr_en;
    assign wdata        = dma_push_req ? DMA_data_bus_in : dev_wr_data;

    // A pop frees a slot, so a full FIFO still accepts a same-cycle push
    assign do_pop  = pop_req && !empty;
    assign do_push = push_req && (!full || do_pop);

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARMED;
                    dir_d   = dir;
                end
                ARMED, XFER: begin
                    if (DACK && EOP) state_d = DONE;
                    else if (DACK)   state_d = XFER;
                    else             state_d = ARMED;
                end
                default: state_d = DONE;
            endcase
        end
    end

    always_comb begin
        wptr_d  = do_push ? wptr_q + 3'd1 : wptr_q;
        rptr_d  = do_pop  ? rptr_q + 3'd1 : rptr_q;
        count_d = count_q + {3'b000, do_push} - {3'b000, do_pop};
        // Head register reads 0 when empty; bypass the write when it lands at the head
        if (count_d == 4'd0)                  head_d = 8'h00;
        else if (do_push && wptr_q == rptr_d) head_d = wdata;
        else                                  head_d = mem_q[rptr_d];
        dreq_d = ((state_q == ARMED) || (state_q == XFER)) && (dir_q ? !full : !empty);
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            wptr_q  <= 3'd0;
            rptr_q  <= 3'd0;
            count_q <= 4'd0;
            head_q  <= 8'h00;
            dreq_q  <= 1'b0;
            ior_q   <= 1'b0;
            iow_q   <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            head_q  <= head_d;
            dreq_q  <= dreq_d;
            ior_q   <= IOR;
            iow_q   <= IOW;
            done_q  <= (state_d == DONE);
            if (push_req && full && !do_pop) ovf_q <= 1'b1;
            if (dma_pop_req && empty)        unr_q <= 1'b1;
        end
    end

    assign DMA_data_bus_out = (DACK && IOR && !empty) ? mem_q[rptr_q] : 8'h00;
    assign DREQ        = dreq_q;
    assign dev_rd_data = head_q;
    assign fifo_count  = count_q;
    assign dev_full    = full;
    assign dev_empty   = empty;
    assign done        = done_q;
    assign overflow    = ovf_q;
    assign underrun    = unr_q;

endmodule

// File: tb/tb_dma_peripheral_port.sv
// Directed bench for dma_peripheral_port; a byte queue tracks FIFO contents
// and supplies the expected data whenever either side reads.
module tb_dma_peripheral_port;

    logic       clk = 1'b0;
    logic       reset, enable, dir, DACK, IOR, IOW, EOP;
    logic [7:0] DMA_data_bus_in, DMA_data_bus_out, dev_wr_data, dev_rd_data;
    logic       dev_wr_en, dev_rd_en, DREQ, dev_full, dev_empty, done, overflow, underrun;
    logic [3:0] fifo_count;

    int total = 0;
    int bad   = 0;
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    dma_peripheral_port dut (
        .clk(clk), .reset(reset), .enable(enable), .dir(dir),
        .DREQ(DREQ), .DACK(DACK), .IOR(IOR), .IOW(IOW), .EOP(EOP),
        .DMA_data_bus_in(DMA_data_bus_in), .DMA_data_bus_out(DMA_data_bus_out),
        .dev_wr_en(dev_wr_en), .dev_wr_data(dev_wr_data),
        .dev_rd_en(dev_rd_en), .dev_rd_data(dev_rd_data),
        .fifo_count(fifo_count), .dev_full(dev_full), .dev_empty(dev_empty),
        .done(done), .overflow(overflow), .underrun(underrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_head();
        return (sb.size() > 0) ? sb[0] : 8'h00;
    endfunction

    task automatic dev_push(input logic [7:0] b);
        dev_wr_en = 1'b1; dev_wr_data = b;
        tick();
        dev_wr_en = 1'b0;
        if (sb.size() < 8) sb.push_back(b);
    endtask

    task automatic dev_pop(input string tag);
        chk(tag, dev_rd_data, exp_head());
        dev_rd_en = 1'b1;
        tick();
        dev_rd_en = 1'b0;
        if (sb.size() > 0) void'(sb.pop_front());
    endtask

    // One IOR pulse; the bus is compared while the strobe is high
    task automatic ior_pulse(input string tag, input bit pops);
        IOR = 1'b1;
        #1;
        chk(tag, DMA_data_bus_out, DACK ? exp_head() : 8'h00);
        tick();
        IOR = 1'b0;
        if (pops && sb.size() > 0) void'(sb.pop_front());
        chk({tag, "_head"}, dev_rd_data, exp_head());
        tick();
    endtask

    task automatic iow_pulse(input logic [7:0] b);
        DMA_data_bus_in = b; IOW = 1'b1;
        tick();
        IOW = 1'b0;
        if (sb.size() < 8) sb.push_back(b);
        tick();
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; dir = 1'b0; DACK = 1'b0; IOR = 1'b0; IOW = 1'b0;
        EOP = 1'b0; DMA_data_bus_in = 8'h00; dev_wr_en = 1'b0; dev_wr_data = 8'h00;
        dev_rd_en = 1'b0;
        tick(); tick();
        chk("rst_dreq", DREQ, 0);
        chk("rst_cnt", fifo_count, 0);
        chk("rst_empty", dev_empty, 1);
        chk("rst_flags", {done, overflow, underrun, dev_full}, 0);
        chk("rst_rd", dev_rd_data, 8'h00);
        reset = 1'b1;
        tick();

        // device-to-memory: three bytes drained by IOR
        dev_push(8'h11); dev_push(8'h22); dev_push(8'h33);
        chk("d2m_cnt3", fifo_count, 3);
        chk("d2m_head", dev_rd_data, 8'h11);
        enable = 1'b1;
        tick();
        chk("d2m_dreq_lag", DREQ, 0);
        tick();
        chk("d2m_dreq", DREQ, 1);
        ior_pulse("ior_nodack", 1'b0);
        chk("ior_nodack_cnt", fifo_count, 3);
        DACK = 1'b1;
        tick();
        ior_pulse("d2m_bus0", 1'b1);
        ior_pulse("d2m_bus1", 1'b1);
        ior_pulse("d2m_bus2", 1'b1);
        chk("d2m_cnt0", fifo_count, 0);
        chk("d2m_dreq_drop", DREQ, 0);
        enable = 1'b0; DACK = 1'b0;
        tick();

        // memory-to-device: fill to full, then overflow
        dir = 1'b1; enable = 1'b1;
        tick(); tick();
        chk("m2d_dreq", DREQ, 1);
        EOP = 1'b1;
        tick();
        EOP = 1'b0;
        chk("eop_nodack", done, 0);
        DACK = 1'b1;
        dir = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) iow_pulse(8'hA0 + 8'(i));
        chk("m2d_full", dev_full, 1);
        chk("m2d_dreq_full", DREQ, 0);
        chk("m2d_no_ovf", overflow, 0);
        iow_pulse(8'hEE);
        chk("m2d_ovf", overflow, 1);
        chk("m2d_cnt8", fifo_count, 8);
        for (int i = 0; i < 8; i++) dev_pop("m2d_devrd");
        chk("m2d_empty", dev_empty, 1);
        tick();
        chk("m2d_dreq_again", DREQ, 1);
        EOP = 1'b1;
        tick();
        EOP = 1'b0;
        chk("eop_done", done, 1);
        tick();
        chk("eop_dreq", DREQ, 0);
        enable = 1'b0; DACK = 1'b0;
        tick();
        chk("done_clr", done, 0);

        // concurrent push/pop at depth 4, twelve pushes wrap the pointers
        dir = 1'b0; enable = 1'b1;
        tick();
        DACK = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) dev_push(8'h30 + 8'(i));
        for (int i = 0; i < 8; i++) begin
            dev_wr_en = 1'b1; dev_wr_data = 8'h40 + 8'(i); IOR = 1'b1;
            #1;
            chk("simul_bus", DMA_data_bus_out, exp_head());
            tick();
            dev_wr_en = 1'b0; IOR = 1'b0;
            void'(sb.pop_front());
            sb.push_back(8'h40 + 8'(i));
            chk("simul_cnt", fifo_count, 4);
            chk("simul_head", dev_rd_data, exp_head());
            tick();
        end
        for (int i = 0; i < 4; i++) ior_pulse("wrap_drain", 1'b1);
        chk("wrap_cnt0", fifo_count, 0);

        // underrun, then reset mid-transfer
        IOR = 1'b1;
        #1;
        chk("unr_bus", DMA_data_bus_out, 8'h00);
        tick();
        IOR = 1'b0;
        chk("unr_flag", underrun, 1);
        chk("unr_cnt", fifo_count, 0);
        tick();
        dev_push(8'h55); dev_push(8'h66);
        tick();
        chk("pre_rst_dreq", DREQ, 1);
        reset = 1'b0; IOR = 1'b1;
        tick();
        sb.delete();
        chk("mid_rst_dreq", DREQ, 0);
        chk("mid_rst_bus", DMA_data_bus_out, 8'h00);
        chk("mid_rst_cnt", fifo_count, 0);
        chk("mid_rst_rd", dev_rd_data, 8'h00);
        chk("mid_rst_flags", {done, overflow, underrun, dev_full, dev_empty}, 5'b00001);
        reset = 1'b1; IOR = 1'b0;
        tick();
        chk("post_rst_dreq", DREQ, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
